// File: rtl/handshake_pkg.sv
// Shared types and defaults for the handshake transmitter and its entry FIFO.
package handshake_pkg;

    localparam int WIDTH_DEF     = 5;
    localparam int DEPTH_DEF     = 2;
    localparam int CNT_W_DEF     = 8;
    localparam int STALL_MAX_DEF = 16;

    typedef struct packed {
        logic                 out_bit;
        logic [WIDTH_DEF-1:0] data;
    } hs_entry_t;

    // Results are computed once at enqueue so the downstream outputs come only from storage.
    function automatic hs_entry_t make_entry(input logic [WIDTH_DEF-1:0] a,
                                             input logic [WIDTH_DEF-1:0] b);
        hs_entry_t e;
        e.out_bit = (|a) & (&b);
        e.data    = a ^ b;
        return e;
    endfunction

endpackage

// File: rtl/handshake_fifo.sv
// DEPTH-entry register FIFO; the head entry is read straight from storage.
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = hs_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  entry_t                     i_din,
    output entry_t                     o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_occ
);

    localparam int AW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_occ;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_occ == (AW+1)'(DEPTH));
    assign o_empty = (r_occ == (AW+1)'(0));
    assign o_occ   = r_occ;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Entry storage; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Read/write pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/handshake_tx_unq1.sv
// Driving end of the single-lane handshake interface: buffers operand results and
// presents them under the ready/valid stability rule, with transfer and stall debug state.
module handshake_tx_unq1
    import handshake_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             handshake_valid,
    input  logic             handshake_ready,
    output logic             out,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] xfer_count,
    output logic             stall_err
);

    hs_entry_t             w_entry;
    hs_entry_t             w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(DEPTH):0] w_occ;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_stall;
    logic                  r_run;
    logic [CNT_W-1:0]      r_xfer;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic                  r_stall_err;

    assign w_entry         = make_entry(in1, in2);
    assign in_ready        = r_run & ~w_full;
    assign handshake_valid = (w_occ != '0);
    assign w_push          = in_valid & in_ready;
    assign w_pop           = handshake_valid & handshake_ready;
    assign w_stall         = handshake_valid & ~handshake_ready;
    assign xfer_count      = r_xfer;
    assign stall_err       = r_stall_err;

    handshake_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (hs_entry_t)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (ASYNCRESETN),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_occ   (w_occ)
    );

    // Head entry is forced to zero when nothing is queued.
    always_comb begin
        out      = 1'b0;
        data_out = '0;
        if (!w_empty) begin
            out      = w_head.out_bit;
            data_out = w_head.data;
        end else begin
            out      = 1'b0;
            data_out = '0;
        end
    end

    // in_ready stays low until the first edge after reset release.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Transfer counter, stall counter (saturating) and sticky stall flag.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_xfer      <= '0;
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_xfer <= r_xfer + CNT_W'(1);
            end
            if (w_pop || w_empty) begin
                r_stall_cnt <= '0;
            end else if (w_stall && (r_stall_cnt != CNT_W'(STALL_MAX))) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                if (r_stall_cnt == CNT_W'(STALL_MAX - 1)) begin
                    r_stall_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_handshake_tx_unq1.sv
// Directed self-checking bench for handshake_tx_unq1.
module tb_handshake_tx_unq1;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in1 = 5'h00;
    logic [4:0] in2 = 5'h00;
    logic       handshake_valid;
    logic       handshake_ready = 1'b0;
    logic       out;
    logic [4:0] data_out;
    logic [7:0] xfer_count;
    logic       stall_err;

    int checks = 0;
    int failures = 0;

    handshake_tx_unq1 dut (
        .CLK             (CLK),
        .ASYNCRESETN     (ASYNCRESETN),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in1             (in1),
        .in2             (in2),
        .handshake_valid (handshake_valid),
        .handshake_ready (handshake_ready),
        .out             (out),
        .data_out        (data_out),
        .xfer_count      (xfer_count),
        .stall_err       (stall_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({in_ready, handshake_valid, out, data_out, xfer_count, stall_err} !== 16'h0000) begin
            failures++; $display("FAIL reset_outputs got=%0h exp=0", {in_ready, handshake_valid, out, data_out, xfer_count, stall_err});
        end
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
        checks++; if (handshake_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid got=%b exp=0", handshake_valid); end
    endtask

    task automatic test_single();
        in1 = 5'h1F; in2 = 5'h1F; in_valid = 1'b1; handshake_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if ({handshake_valid, out, data_out} !== {1'b1, 1'b1, 5'h00}) begin
            failures++; $display("FAIL single_head got=%b/%b/%0h exp=1/1/0", handshake_valid, out, data_out);
        end
        checks++; if (xfer_count !== 8'd0) begin failures++; $display("FAIL single_cnt_pre got=%0d exp=0", xfer_count); end
        tick();
        checks++; if (xfer_count !== 8'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", xfer_count); end
        checks++; if (handshake_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", handshake_valid); end
    endtask

    task automatic test_backpressure();
        handshake_ready = 1'b0;
        in_valid = 1'b1; in1 = 5'h01; in2 = 5'h1F;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after1 got=%b exp=1", in_ready); end
        in1 = 5'h00; in2 = 5'h03;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({handshake_valid, out, data_out} !== {1'b1, 1'b1, 5'h1E}) begin
                failures++; $display("FAIL bp_stable cyc=%0d got=%b/%b/%0h exp=1/1/1e", i, handshake_valid, out, data_out);
            end
            tick();
        end
        handshake_ready = 1'b1;
        tick();
        checks++; if ({handshake_valid, out, data_out} !== {1'b1, 1'b0, 5'h03}) begin
            failures++; $display("FAIL bp_drain2 got=%b/%b/%0h exp=1/0/3", handshake_valid, out, data_out);
        end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
        tick();
        checks++; if ({handshake_valid, xfer_count} !== {1'b0, 8'd3}) begin
            failures++; $display("FAIL bp_done got=%b/%0d exp=0/3", handshake_valid, xfer_count);
        end
        handshake_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] a;
        logic [4:0] b;
        logic [7:0] exp_cnt;
        handshake_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            a = 5'(k);
            b = 5'(k * 7 + 3);
            in1 = a; in2 = b;
            tick();
            exp_cnt = 8'(3 + k);
            checks++; if ({handshake_valid, in_ready, out, data_out, xfer_count} !==
                          {1'b1, 1'b1, ((|a) & (&b)), a ^ b, exp_cnt}) begin
                failures++; $display("FAIL stream k=%0d got=%b/%b/%b/%0h/%0d exp=1/1/%b/%0h/%0d",
                    k, handshake_valid, in_ready, out, data_out, xfer_count, ((|a) & (&b)), a ^ b, exp_cnt);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if ({handshake_valid, xfer_count} !== {1'b0, 8'd47}) begin
            failures++; $display("FAIL stream_wrap got=%b/%0d exp=0/47", handshake_valid, xfer_count);
        end
        handshake_ready = 1'b0;
    endtask

    task automatic test_stall();
        handshake_ready = 1'b0;
        in_valid = 1'b1; in1 = 5'h0A; in2 = 5'h1F;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL stall_early got=%b exp=0", stall_err); end
            end
        end
        checks++; if (stall_err !== 1'b1) begin failures++; $display("FAIL stall_set got=%b exp=1", stall_err); end
        checks++; if ({handshake_valid, out, data_out} !== {1'b1, 1'b1, 5'h15}) begin
            failures++; $display("FAIL stall_hold got=%b/%b/%0h exp=1/1/15", handshake_valid, out, data_out);
        end
        handshake_ready = 1'b1;
        tick();
        checks++; if ({handshake_valid, stall_err, xfer_count} !== {1'b0, 1'b1, 8'd48}) begin
            failures++; $display("FAIL stall_sticky got=%b/%b/%0d exp=0/1/48", handshake_valid, stall_err, xfer_count);
        end
        handshake_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in1 = 5'h1F; in2 = 5'h1F;
        tick();
        in1 = 5'h02; in2 = 5'h05;
        tick();
        in_valid = 1'b0;
        checks++; if ({handshake_valid, in_ready} !== 2'b10) begin
            failures++; $display("FAIL ar_queued got=%b%b exp=10", handshake_valid, in_ready);
        end
        @(negedge CLK);
        #2 ASYNCRESETN = 1'b0;
        #1;
        checks++; if ({in_ready, handshake_valid, out, data_out, xfer_count, stall_err} !== 16'h0000) begin
            failures++; $display("FAIL ar_cleared got=%0h exp=0", {in_ready, handshake_valid, out, data_out, xfer_count, stall_err});
        end
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        tick();
        checks++; if ({in_ready, handshake_valid} !== 2'b10) begin
            failures++; $display("FAIL ar_release got=%b%b exp=10", in_ready, handshake_valid);
        end
    endtask

    task automatic test_full();
        handshake_ready = 1'b0;
        in_valid = 1'b1; in1 = 5'h03; in2 = 5'h1F;
        tick();
        in1 = 5'h07; in2 = 5'h01;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        in1 = 5'h10; in2 = 5'h1F; handshake_ready = 1'b1;
        tick();
        checks++; if ({in_ready, handshake_valid, out, data_out, xfer_count} !== {1'b1, 1'b1, 1'b0, 5'h06, 8'd1}) begin
            failures++; $display("FAIL full_deq got=%b/%b/%b/%0h/%0d exp=1/1/0/6/1", in_ready, handshake_valid, out, data_out, xfer_count);
        end
        tick();
        in_valid = 1'b0;
        checks++; if ({handshake_valid, out, data_out, xfer_count} !== {1'b1, 1'b1, 5'h0F, 8'd2}) begin
            failures++; $display("FAIL full_next got=%b/%b/%0h/%0d exp=1/1/f/2", handshake_valid, out, data_out, xfer_count);
        end
        tick();
        checks++; if ({handshake_valid, xfer_count} !== {1'b0, 8'd3}) begin
            failures++; $display("FAIL full_end got=%b/%0d exp=0/3", handshake_valid, xfer_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
